// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard unit: ALU operand select encodings,
// controller states and the in-flight pipeline slot record.
package fwd_hazard_unit_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        HOLD     = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       wr_en;
        logic [4:0] wr_reg;
        logic       is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // Register 0 is hardwired to zero, so nothing ever produces it.
    function automatic logic slot_produces(input slot_t s, input logic [4:0] r);
        return s.valid && s.wr_en && (s.wr_reg == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/fwd_src_cmp.sv
// Compares one ID-stage source register against the EX and MEM slots and returns the
// operand select plus the raw hit flags the hazard logic needs.
module fwd_src_cmp
    import fwd_hazard_unit_pkg::*;
(
    input  logic [4:0] src,
    input  logic       src_used,
    input  slot_t      ex_slot,
    input  slot_t      mem_slot,
    output logic [1:0] sel,
    output logic       ex_hit,
    output logic       ex_load_hit,
    output logic       mem_hit
);

    // The EX slot is the youngest producer, so it takes priority over MEM.
    always_comb begin
        ex_hit      = src_used && slot_produces(ex_slot, src);
        mem_hit     = src_used && slot_produces(mem_slot, src);
        ex_load_hit = ex_hit && ex_slot.is_load;
        sel         = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EXMEM;
        end else if (mem_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard controller for a 5-stage pipeline. Define FWD_UNIT_FWD_EN to
// enable operand forwarding; without it every RAW hazard is resolved by stalling.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_wr_en,
    input  logic [4:0] id_wr_reg,
    input  logic       id_is_load,
    input  logic       mem_busy,
    input  logic       flush,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall,
    output logic       freeze
);

    state_e     state_q, state_d;
    slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0] sel_a, sel_b;
    logic       a_ex_hit, a_ex_load_hit, a_mem_hit;
    logic       b_ex_hit, b_ex_load_hit, b_mem_hit;
    logic       hazard;
    logic       unused_bits;

    fwd_src_cmp u_cmp_rs (
        .src         (id_rs),
        .src_used    (id_use_rs),
        .ex_slot     (ex_q),
        .mem_slot    (mem_q),
        .sel         (sel_a),
        .ex_hit      (a_ex_hit),
        .ex_load_hit (a_ex_load_hit),
        .mem_hit     (a_mem_hit)
    );

    fwd_src_cmp u_cmp_rt (
        .src         (id_rt),
        .src_used    (id_use_rt),
        .ex_slot     (ex_q),
        .mem_slot    (mem_q),
        .sel         (sel_b),
        .ex_hit      (b_ex_hit),
        .ex_load_hit (b_ex_load_hit),
        .mem_hit     (b_mem_hit)
    );

    // WB only exists to model the pipeline depth; not every hit flag is needed in each build.
    assign unused_bits = ^{wb_q, mem_q.is_load, sel_a, sel_b, a_ex_hit, a_mem_hit,
                           b_ex_hit, b_mem_hit, a_ex_load_hit, b_ex_load_hit};

    // Flush kills the ID instruction, so it can never be the cause of a stall.
    always_comb begin
`ifdef FWD_UNIT_FWD_EN
        hazard = id_valid && (a_ex_load_hit || b_ex_load_hit);
`else
        hazard = id_valid && (a_ex_hit || a_mem_hit || b_ex_hit || b_mem_hit);
`endif
        freeze = !rst && mem_busy;
        stall  = !rst && !mem_busy && !flush && hazard && (state_q != LU_STALL);
    end

    always_comb begin
        state_d = RUN;
        if (mem_busy) begin
            state_d = HOLD;
        end
`ifdef FWD_UNIT_FWD_EN
        else if (stall) begin
            state_d = LU_STALL;
        end
`endif
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = SLOT_EMPTY;
            if (id_valid && !stall && !flush) begin
                ex_d.valid   = 1'b1;
                ex_d.wr_en   = id_wr_en;
                ex_d.wr_reg  = id_wr_reg;
                ex_d.is_load = id_is_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ex_q    <= SLOT_EMPTY;
            mem_q   <= SLOT_EMPTY;
            wb_q    <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

`ifdef FWD_UNIT_FWD_EN
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    // Selects follow the instruction into EX; a bubble entering EX gets regfile selects.
    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!freeze) begin
            fwd_a_d = ex_d.valid ? sel_a : FWD_RF;
            fwd_b_d = ex_d.valid ? sel_b : FWD_RF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
`else
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit; expectations follow FWD_UNIT_FWD_EN.
module tb_fwd_hazard_unit;

    typedef struct {
        logic       rst, busy, fl, iv;
        logic [4:0] rs, rt;
        logic       urs, urt, we;
        logic [4:0] wd;
        logic       ld;
        logic       st, fz;
        logic [1:0] ea, eb;
    } vec_t;

    typedef struct {
        int         idx;
        logic       st, fz;
        logic [1:0] ea, eb;
    } exp_t;

    logic       clk, rst, id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, mem_busy, flush;
    logic [4:0] id_rs, id_rt, id_wr_reg;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, freeze;

    vec_t vec_q[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    fwd_hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wr_en   (id_wr_en),
        .id_wr_reg  (id_wr_reg),
        .id_is_load (id_is_load),
        .mem_busy   (mem_busy),
        .flush      (flush),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall      (stall),
        .freeze     (freeze)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic row(input logic r, bz, f, iv, input logic [4:0] rs_i, rt_i,
                       input logic urs_i, urt_i, we_i, input logic [4:0] wd_i, input logic ld_i,
                       input logic st_i, fz_i, input logic [1:0] ea_i, eb_i);
        vec_t v;
        v = '{rst: r, busy: bz, fl: f, iv: iv, rs: rs_i, rt: rt_i, urs: urs_i, urt: urt_i,
              we: we_i, wd: wd_i, ld: ld_i, st: st_i, fz: fz_i, ea: ea_i, eb: eb_i};
        vec_q.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        rst        = v.rst;
        mem_busy   = v.busy;
        flush      = v.fl;
        id_valid   = v.iv;
        id_rs      = v.rs;
        id_rt      = v.rt;
        id_use_rs  = v.urs;
        id_use_rt  = v.urt;
        id_wr_en   = v.we;
        id_wr_reg  = v.wd;
        id_is_load = v.ld;
        e = '{idx: idx, st: v.st, fz: v.fz, ea: v.ea, eb: v.eb};
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks += 4;
        if (stall !== e.st) begin
            failures++;
            $display("[TB] FAIL row%0d stall actual=%0b expected=%0b", e.idx, stall, e.st);
        end
        if (freeze !== e.fz) begin
            failures++;
            $display("[TB] FAIL row%0d freeze actual=%0b expected=%0b", e.idx, freeze, e.fz);
        end
        if (fwd_a_sel !== e.ea) begin
            failures++;
            $display("[TB] FAIL row%0d fwd_a_sel actual=%b expected=%b", e.idx, fwd_a_sel, e.ea);
        end
        if (fwd_b_sel !== e.eb) begin
            failures++;
            $display("[TB] FAIL row%0d fwd_b_sel actual=%b expected=%b", e.idx, fwd_b_sel, e.eb);
        end
    endtask

    // Monitor: compares on the falling edge, half a cycle after the inputs settle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; mem_busy = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wr_en = 1'b0; id_wr_reg = '0; id_is_load = 1'b0;

`ifdef FWD_UNIT_FWD_EN
        row(1,1,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,3,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 3,1,1,1, 1,4,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b01,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,3,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,3,1,1, 1,5,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b10);
        row(0,0,0, 1, 1,0,1,0, 1,2,1, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 2,2,1,1, 1,6,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 2,2,1,1, 1,6,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b10,2'b10);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 0,0,1,1, 1,7,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,0,1,0, 1,2,1, 0,0,2'b00,2'b00);
        row(0,1,0, 1, 2,2,1,1, 1,6,0, 0,1,2'b00,2'b00);
        row(0,1,0, 1, 2,2,1,1, 1,6,0, 0,1,2'b00,2'b00);
        row(0,1,0, 1, 2,2,1,1, 1,6,0, 0,1,2'b00,2'b00);
        row(0,0,0, 1, 2,2,1,1, 1,6,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 2,2,1,1, 1,6,0, 0,0,2'b00,2'b00);
        row(0,1,0, 0, 0,0,0,0, 0,0,0, 0,1,2'b10,2'b10);
        row(0,1,0, 0, 0,0,0,0, 0,0,0, 0,1,2'b10,2'b10);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b10,2'b10);
        row(0,0,0, 1, 1,0,1,0, 1,2,1, 0,0,2'b00,2'b00);
        row(0,0,1, 1, 2,2,1,1, 1,6,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 2,2,1,1, 1,6,0, 0,0,2'b00,2'b00);
        row(0,1,1, 0, 0,0,0,0, 0,0,0, 0,1,2'b10,2'b10);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b10,2'b10);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,0,1,0, 1,2,1, 0,0,2'b00,2'b00);
        row(1,0,0, 1, 2,2,1,1, 1,6,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 2,2,1,1, 1,6,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,0,1,0, 1,2,1, 0,0,2'b00,2'b00);
        row(1,1,0, 1, 2,2,1,1, 1,6,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 2,2,1,1, 1,6,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,3,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 3,3,0,1, 1,4,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b01);
`else
        row(1,1,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,3,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 3,1,1,1, 1,4,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 3,1,1,1, 1,4,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 3,1,1,1, 1,4,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,3,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,3,1,1, 1,5,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 1,3,1,1, 1,5,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,0,1,0, 1,2,1, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 2,2,1,1, 1,6,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 2,2,1,1, 1,6,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 2,2,1,1, 1,6,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 0,0,1,1, 1,7,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,3,0, 0,0,2'b00,2'b00);
        row(0,1,0, 1, 3,1,1,1, 1,4,0, 0,1,2'b00,2'b00);
        row(0,1,0, 1, 3,1,1,1, 1,4,0, 0,1,2'b00,2'b00);
        row(0,1,0, 1, 3,1,1,1, 1,4,0, 0,1,2'b00,2'b00);
        row(0,0,0, 1, 3,1,1,1, 1,4,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 3,1,1,1, 1,4,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 3,1,1,1, 1,4,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,3,0, 0,0,2'b00,2'b00);
        row(0,0,1, 1, 3,1,1,1, 1,4,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 4,4,1,1, 1,5,0, 0,0,2'b00,2'b00);
        row(0,1,1, 0, 0,0,0,0, 0,0,0, 0,1,2'b00,2'b00);
        row(0,0,0, 1, 5,5,1,1, 1,6,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 5,5,1,1, 1,6,0, 1,0,2'b00,2'b00);
        row(0,0,0, 1, 5,5,1,1, 1,6,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,3,0, 0,0,2'b00,2'b00);
        row(1,0,0, 1, 3,1,1,1, 1,4,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 3,1,1,1, 1,4,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,3,0, 0,0,2'b00,2'b00);
        row(1,1,0, 1, 3,1,1,1, 1,4,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 3,1,1,1, 1,4,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 1,2,1,1, 1,3,0, 0,0,2'b00,2'b00);
        row(0,0,0, 1, 3,1,0,1, 1,4,0, 0,0,2'b00,2'b00);
        row(0,0,0, 0, 0,0,0,0, 0,0,0, 0,0,2'b00,2'b00);
`endif

        for (int i = 0; i < vec_q.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vec_q[i], i);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
